// File: rtl/id_ex_stage_if.sv
// ============================================================================
//  id_ex_stage_if
//  Decode-to-execute bus bundle for the 16-bit core.
//  Revision: 1.0 - initial release
//
//  Signals (direction as seen by the stage, modport slave):
//    ctrl_in     in   12      decoder control word [11:7] EX, [6:2] MEM, [1:0] WB
//    instr_in    in   16      IF/ID instruction; rd=[11:8], rs=[7:4], rt=[3:0]
//    rs_data_in  in   DATA_W  register-file read port A
//    rt_data_in  in   DATA_W  register-file read port B
//    flush_i     in   1       kill the instruction entering EX
//    ex_ctrl_o   out  5       latched EX control
//    mem_ctrl_o  out  5       latched MEM control; [4]=doubleRead, [3]=doubleWrite
//    wb_ctrl_o   out  2       latched WB control; [1]=MemToReg, [0]=RegWrite
//    rs_data_o   out  DATA_W  latched read data A
//    rt_data_o   out  DATA_W  latched read data B
//    rd_o/rs_o/rt_o out REG_AW latched register fields
//    imm_o       out  DATA_W  latched zero-extended instr_in[7:0]
//    stall_o     out  1       combinational front-end hold
//    second_o    out  1       EX/MEM holds beat 2 of a double op
//    bubble_cnt_o out 16      only when ID_EX_BUBBLE_CNT_EN is defined
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic [11:0]       ctrl_in;
    logic [15:0]       instr_in;
    logic [DATA_W-1:0] rs_data_in;
    logic [DATA_W-1:0] rt_data_in;
    logic              flush_i;

    logic [4:0]        ex_ctrl_o;
    logic [4:0]        mem_ctrl_o;
    logic [1:0]        wb_ctrl_o;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [REG_AW-1:0] rd_o;
    logic [REG_AW-1:0] rs_o;
    logic [REG_AW-1:0] rt_o;
    logic [DATA_W-1:0] imm_o;
    logic              stall_o;
    logic              second_o;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0]       bubble_cnt_o;

    modport master (
        output ctrl_in, instr_in, rs_data_in, rt_data_in, flush_i,
        input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, rs_data_o, rt_data_o,
        input  rd_o, rs_o, rt_o, imm_o, stall_o, second_o, bubble_cnt_o
    );

    modport slave (
        input  ctrl_in, instr_in, rs_data_in, rt_data_in, flush_i,
        output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, rs_data_o, rt_data_o,
        output rd_o, rs_o, rt_o, imm_o, stall_o, second_o, bubble_cnt_o
    );
`else
    modport master (
        output ctrl_in, instr_in, rs_data_in, rt_data_in, flush_i,
        input  ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, rs_data_o, rt_data_o,
        input  rd_o, rs_o, rt_o, imm_o, stall_o, second_o
    );

    modport slave (
        input  ctrl_in, instr_in, rs_data_in, rt_data_in, flush_i,
        output ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, rs_data_o, rt_data_o,
        output rd_o, rs_o, rt_o, imm_o, stall_o, second_o
    );
`endif
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  id_ex_stage
//  Decode-to-execute pipeline register for the 16-bit core. Latches control,
//  register data and instruction fields, inserts load-use bubbles, and holds
//  the front end one cycle for the second beat of doubleRead/doubleWrite ops.
//  Revision: 1.0 - initial release
//
//  Ports:
//    clk   in   rising-edge clock
//    rst   in   asynchronous active-high reset
//    bus   id_ex_stage_if.slave - decode inputs and EX-side outputs
//
//  Optional feature macro: ID_EX_BUBBLE_CNT_EN
//    When defined, bus.bubble_cnt_o counts inserted bubbles (hazard or
//    flush), saturating at 16'hFFFF.
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    id_ex_stage_if.slave    bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DBL  = 1'b1
    } state_t;

    state_t            state_q;
    logic [4:0]        ex_ctrl_q;
    logic [4:0]        mem_ctrl_q;
    logic [1:0]        wb_ctrl_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [DATA_W-1:0] imm_q;
    logic              second_q;

    logic [REG_AW-1:0] w_rd_field;
    logic [REG_AW-1:0] w_rs_field;
    logic [REG_AW-1:0] w_rt_field;
    logic [DATA_W-1:0] w_imm;
    logic              w_is_double;
    logic              w_hazard;
    logic              unused_opcode;

    assign w_rd_field  = REG_AW'(bus.instr_in[11:8]);
    assign w_rs_field  = REG_AW'(bus.instr_in[7:4]);
    assign w_rt_field  = REG_AW'(bus.instr_in[3:0]);
    assign w_imm       = {{(DATA_W-8){1'b0}}, bus.instr_in[7:0]};
    assign w_is_double = bus.ctrl_in[6] | bus.ctrl_in[5];
    assign unused_opcode = ^bus.instr_in[15:12];

    // Load in EX (MemToReg and RegWrite) whose destination feeds the
    // instruction in ID. r0 is hard-wired, so it never creates a dependency.
    // Only meaningful in IDLE; in DBL the front end is already held.
    assign w_hazard = (state_q == S_IDLE)
                    && (wb_ctrl_q == 2'b11)
                    && (rd_q != '0)
                    && ((rd_q == w_rs_field) || (rd_q == w_rt_field));

    // No path from flush_i: the front end hold is independent of a kill.
    assign bus.stall_o = (state_q == S_DBL) || w_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ex_ctrl_q  <= '0;
            mem_ctrl_q <= '0;
            wb_ctrl_q  <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            imm_q      <= '0;
            second_q   <= 1'b0;
        end else if (bus.flush_i) begin
            // Bubble the control word; data fields are don't-care and simply load.
            state_q    <= S_IDLE;
            second_q   <= 1'b0;
            ex_ctrl_q  <= '0;
            mem_ctrl_q <= '0;
            wb_ctrl_q  <= '0;
            rs_data_q  <= bus.rs_data_in;
            rt_data_q  <= bus.rt_data_in;
            rd_q       <= w_rd_field;
            rs_q       <= w_rs_field;
            rt_q       <= w_rt_field;
            imm_q      <= w_imm;
        end else if (state_q == S_DBL) begin
            // Beat 2 of the double op: everything latched holds.
            state_q  <= S_IDLE;
            second_q <= 1'b0;
        end else if (w_hazard) begin
            ex_ctrl_q  <= '0;
            mem_ctrl_q <= '0;
            wb_ctrl_q  <= '0;
        end else begin
            ex_ctrl_q  <= bus.ctrl_in[11:7];
            mem_ctrl_q <= bus.ctrl_in[6:2];
            wb_ctrl_q  <= bus.ctrl_in[1:0];
            rs_data_q  <= bus.rs_data_in;
            rt_data_q  <= bus.rt_data_in;
            rd_q       <= w_rd_field;
            rs_q       <= w_rs_field;
            rt_q       <= w_rt_field;
            imm_q      <= w_imm;
            if (w_is_double) begin
                state_q  <= S_DBL;
                second_q <= 1'b1;
            end
        end
    end

    assign bus.ex_ctrl_o  = ex_ctrl_q;
    assign bus.mem_ctrl_o = mem_ctrl_q;
    assign bus.wb_ctrl_o  = wb_ctrl_q;
    assign bus.rs_data_o  = rs_data_q;
    assign bus.rt_data_o  = rt_data_q;
    assign bus.rd_o       = rd_q;
    assign bus.rs_o       = rs_q;
    assign bus.rt_o       = rt_q;
    assign bus.imm_o      = imm_q;
    assign bus.second_o   = second_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q;
    logic [15:0] bubble_cnt_d;
    logic        w_bubble;

    // A flush always bubbles; a hazard bubbles only when not overridden.
    assign w_bubble = bus.flush_i || w_hazard;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (w_bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  tb_id_ex_stage
//  Self-checking bench for id_ex_stage: a directed vector table, hand-written
//  reset/saturation sequences and randomized traffic against a reference model.
//  Revision: 1.0 - initial release
//  Optional feature macro: ID_EX_BUBBLE_CNT_EN (bubble counter checks).
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(16), .REG_AW(4)) bus ();

    id_ex_stage #(.DATA_W(16), .REG_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what EX should hold, plus whether beat 2 is pending.
    logic [11:0] m_ctrl;
    logic [15:0] m_rsd, m_rtd, m_imm;
    logic [3:0]  m_rd, m_rs, m_rt;
    logic        m_beat2;
    int          m_bubbles;

    typedef struct {
        logic        flush;
        logic [11:0] ctrl;
        logic [15:0] instr;
        logic        exp_stall;
        logic [11:0] exp_ctrl;
        logic        exp_second;
        logic [3:0]  exp_rd;
        int          exp_ld;     // row whose rs data EX should hold afterwards
    } vec_t;

    vec_t vt [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
        m_rd = '0; m_rs = '0; m_rt = '0; m_beat2 = 1'b0; m_bubbles = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".ctrl"}, {20'd0, bus.ex_ctrl_o, bus.mem_ctrl_o, bus.wb_ctrl_o}, {20'd0, m_ctrl});
        chk({tag, ".rs_data"}, {16'd0, bus.rs_data_o}, {16'd0, m_rsd});
        chk({tag, ".rt_data"}, {16'd0, bus.rt_data_o}, {16'd0, m_rtd});
        chk({tag, ".fields"}, {20'd0, bus.rd_o, bus.rs_o, bus.rt_o}, {20'd0, m_rd, m_rs, m_rt});
        chk({tag, ".imm"}, {16'd0, bus.imm_o}, {16'd0, m_imm});
        chk({tag, ".second"}, {31'd0, bus.second_o}, {31'd0, m_beat2});
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({tag, ".bubble_cnt"}, {16'd0, bus.bubble_cnt_o}, m_bubbles);
`endif
    endtask

    // One clock: drive inputs, check stall before the edge, advance model
    // after the edge and compare everything. Entered at posedge+1.
    task automatic step(input logic f, input logic [11:0] c, input logic [15:0] ins,
                        input logic [15:0] a, input logic [15:0] b, output logic st);
        logic hz;
        bus.flush_i = f; bus.ctrl_in = c; bus.instr_in = ins;
        bus.rs_data_in = a; bus.rt_data_in = b;
        #3;
        // A load in EX that writes a non-zero register read by this instruction.
        hz = !m_beat2 && (m_ctrl[1:0] == 2'b11) && (m_rd != 4'd0)
             && ((m_rd == ins[7:4]) || (m_rd == ins[3:0]));
        st = bus.stall_o;
        chk("model.stall", {31'd0, st}, {31'd0, m_beat2 | hz});
        @(posedge clk);
        #1;
        if (f || hz) begin
            if (m_bubbles < 65535) m_bubbles++;
        end
        if (f) begin
            m_ctrl = '0; m_beat2 = 1'b0;
            m_rsd = a; m_rtd = b; m_rd = ins[11:8]; m_rs = ins[7:4]; m_rt = ins[3:0];
            m_imm = {8'd0, ins[7:0]};
        end else if (m_beat2) begin
            m_beat2 = 1'b0;
        end else if (hz) begin
            m_ctrl = '0;
        end else begin
            m_ctrl = c;
            m_rsd = a; m_rtd = b; m_rd = ins[11:8]; m_rs = ins[7:4]; m_rt = ins[3:0];
            m_imm = {8'd0, ins[7:0]};
            m_beat2 = c[6] | c[5];   // doubleRead or doubleWrite
        end
        compare_all("model");
    endtask

    initial begin
        logic st;
        logic [11:0] rc;
        logic [15:0] ri;

        //          flush  ctrl     instr     stall ctrl    second rd    ld
        vt[0]  = '{1'b0, 12'h003, 16'h0312, 1'b0, 12'h003, 1'b0, 4'h3, 0};
        vt[1]  = '{1'b0, 12'h001, 16'h0530, 1'b1, 12'h000, 1'b0, 4'h3, 0};
        vt[2]  = '{1'b0, 12'h001, 16'h0530, 1'b0, 12'h001, 1'b0, 4'h5, 2};
        vt[3]  = '{1'b0, 12'h040, 16'h0600, 1'b0, 12'h040, 1'b1, 4'h6, 3};
        vt[4]  = '{1'b0, 12'h002, 16'h0700, 1'b1, 12'h040, 1'b0, 4'h6, 3};
        vt[5]  = '{1'b0, 12'h002, 16'h0700, 1'b0, 12'h002, 1'b0, 4'h7, 5};
        vt[6]  = '{1'b0, 12'h003, 16'h0000, 1'b0, 12'h003, 1'b0, 4'h0, 6};
        vt[7]  = '{1'b0, 12'h001, 16'h0800, 1'b0, 12'h001, 1'b0, 4'h8, 7};
        vt[8]  = '{1'b0, 12'h023, 16'h0900, 1'b0, 12'h023, 1'b1, 4'h9, 8};
        vt[9]  = '{1'b0, 12'h001, 16'h0A90, 1'b1, 12'h023, 1'b0, 4'h9, 8};
        vt[10] = '{1'b0, 12'h001, 16'h0A90, 1'b1, 12'h000, 1'b0, 4'h9, 8};
        vt[11] = '{1'b0, 12'h001, 16'h0A90, 1'b0, 12'h001, 1'b0, 4'hA, 11};
        vt[12] = '{1'b0, 12'h040, 16'h0B00, 1'b0, 12'h040, 1'b1, 4'hB, 12};
        vt[13] = '{1'b0, 12'h020, 16'h0C00, 1'b1, 12'h040, 1'b0, 4'hB, 12};
        vt[14] = '{1'b0, 12'h020, 16'h0C00, 1'b0, 12'h020, 1'b1, 4'hC, 14};
        vt[15] = '{1'b0, 12'h000, 16'h0D00, 1'b1, 12'h020, 1'b0, 4'hC, 14};
        vt[16] = '{1'b0, 12'h040, 16'h0E00, 1'b0, 12'h040, 1'b1, 4'hE, 16};
        vt[17] = '{1'b1, 12'h003, 16'h0F00, 1'b1, 12'h000, 1'b0, 4'hF, 17};
        vt[18] = '{1'b0, 12'h001, 16'h0100, 1'b0, 12'h001, 1'b0, 4'h1, 18};
        vt[19] = '{1'b0, 12'h003, 16'h0200, 1'b0, 12'h003, 1'b0, 4'h2, 19};
        vt[20] = '{1'b0, 12'h001, 16'h0302, 1'b1, 12'h000, 1'b0, 4'h2, 19};
        vt[21] = '{1'b0, 12'h001, 16'h0302, 1'b0, 12'h001, 1'b0, 4'h3, 21};
        vt[22] = '{1'b1, 12'h001, 16'h0400, 1'b0, 12'h000, 1'b0, 4'h4, 22};

        rst = 1'b1;
        bus.flush_i = 1'b0; bus.ctrl_in = '0; bus.instr_in = '0;
        bus.rs_data_in = '0; bus.rt_data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        chk("reset.stall", {31'd0, bus.stall_o}, 32'd0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 23; i++) begin
            step(vt[i].flush, vt[i].ctrl, vt[i].instr, 16'hA000 + 16'(i), 16'hB000 + 16'(i), st);
            chk($sformatf("vec%0d.stall", i), {31'd0, st}, {31'd0, vt[i].exp_stall});
            chk($sformatf("vec%0d.ctrl", i), {20'd0, bus.ex_ctrl_o, bus.mem_ctrl_o, bus.wb_ctrl_o},
                {20'd0, vt[i].exp_ctrl});
            chk($sformatf("vec%0d.second", i), {31'd0, bus.second_o}, {31'd0, vt[i].exp_second});
            chk($sformatf("vec%0d.rd", i), {28'd0, bus.rd_o}, {28'd0, vt[i].exp_rd});
            chk($sformatf("vec%0d.rs_data", i), {16'd0, bus.rs_data_o}, 32'hA000 + 32'(vt[i].exp_ld));
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("table.bubble_cnt", {16'd0, bus.bubble_cnt_o}, 32'd5);
`endif

        // Asynchronous reset while in DBL, between clock edges.
        step(1'b0, 12'h040, 16'h0650, 16'h1234, 16'h5678, st);
        chk("dbl.second_before_rst", {31'd0, bus.second_o}, 32'd1);
        chk("dbl.stall_before_rst", {31'd0, bus.stall_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        chk("async_rst.stall", {31'd0, bus.stall_o}, 32'd0);
        rst = 1'b0;
        bus.ctrl_in = '0; bus.instr_in = '0;
        step(1'b0, 12'h000, 16'h0000, 16'h0000, 16'h0000, st);

        // Randomized traffic, narrowed register numbers to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            rc = 12'($urandom) & 12'hF9F;
            if ($urandom_range(0, 5) == 0) rc[6] = 1'b1;
            if ($urandom_range(0, 5) == 0) rc[5] = 1'b1;
            if ($urandom_range(0, 1) == 0) rc[1:0] = 2'b11;
            ri = 16'($urandom);
            ri[11:8] = 4'($urandom_range(0, 3));
            ri[7:4]  = 4'($urandom_range(0, 3));
            ri[3:0]  = 4'($urandom_range(0, 3));
            step(($urandom_range(0, 9) == 0), rc, ri, 16'($urandom), 16'($urandom), st);
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        // Keep flushing until the counter must have saturated.
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
        step(1'b0, 12'h000, 16'h0000, 16'h0000, 16'h0000, st);
        for (int n = 0; n < 65540; n++) begin
            step(1'b1, 12'h001, 16'h0100, 16'h0000, 16'h0000, st);
        end
        chk("sat.bubble_cnt", {16'd0, bus.bubble_cnt_o}, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
